stream_arbiter_qos_rr: RTL and testbench
========================================

STREAM_ARBITER_QOS_RR -- requirements
Module: stream_arbiter_qos_rr

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, width of data beat.
REQ-002 SHALL have parameter T_QOS__WIDTH, default 4, width of QoS field.
REQ-003 SHALL have parameter STREAM_COUNT, default 4, number of input streams (2..16).
REQ-004 SHALL have parameter T_ID___WIDTH, default $clog2(STREAM_COUNT), width of stream id.
REQ-005 SHALL have clk_i input, 1 bit, single clock; all logic on rising edge.
REQ-006 SHALL have rst_i input, 1 bit, reset, asynchronous, active-high.
REQ-007 SHALL have s_data_i input, T_DATA_WIDTH x STREAM_COUNT (unpacked array), per-stream data.
REQ-008 SHALL have s_qos_i input, T_QOS__WIDTH x STREAM_COUNT (unpacked array), per-stream QoS.
REQ-009 SHALL have s_last_i, s_valid_i inputs and s_ready_o output, STREAM_COUNT each, per-stream last/valid/ready.
REQ-010 SHALL have m_data_o, m_qos_o, m_id_o, m_last_o outputs, widths T_DATA_WIDTH/T_QOS__WIDTH/T_ID___WIDTH/1, output beat.
REQ-011 SHALL have m_valid_o output and m_ready_i input, 1 bit each, output handshake.

Function
REQ-012 SHALL use FSM states IDLE (no grant) and PKT (stream locked); IDLE->PKT when any s_valid_i set; PKT->IDLE when beat with s_last_i accepted.
REQ-013 SHALL arbitrate in IDLE among valid streams: candidates = streams with highest s_qos_i; a stream with qos 0 SHALL be treated as equal to that highest level.
REQ-014 SHALL break ties round-robin: first candidate at index > last granted id, wrapping modulo STREAM_COUNT.
REQ-015 SHALL register grant id and s_qos_i of winner at arbitration; m_qos_o and m_id_o constant for whole packet.
REQ-016 SHALL hold the lock until last beat accepted; changes of other streams' valid/qos during packet SHALL be ignored.
REQ-017 SHALL drive s_ready_o[g] = (state==PKT) & (g==grant) & (~m_valid_o | m_ready_i); all other bits 0.
REQ-018 SHALL register accepted beat into output stage: latency 1 cycle, throughput 1 beat/cycle, no beat lost or duplicated.
REQ-019 SHALL hold m_data_o/m_last_o/m_valid_o stable while m_valid_o & ~m_ready_i; m_valid_o falls only after acceptance with no new beat.
REQ-020 SHALL insert exactly one IDLE cycle between packets (default build).
REQ-021 SHALL, when granted stream drops valid mid-packet, stall with s_ready and lock kept; no timeout.

Reset
REQ-022 SHALL, while rst_i high, force m_valid_o, m_last_o, m_data_o, m_qos_o, m_id_o, s_ready_o to 0, state to IDLE.
REQ-023 SHALL reset last-granted pointer to STREAM_COUNT-1 so stream 0 wins first tie.
REQ-024 SHALL, on reset asserted mid-packet, discard packet and pending output beat; resume in IDLE after release.

Configuration
REQ-025 SHALL support macro STREAM_ARB_BACK2BACK_EN: defined -> arbitration performed combinationally in the cycle the last beat is accepted, next packet's first beat accepted next cycle (zero bubble); undefined -> REQ-020 behaviour.

Structure
REQ-026 SHALL place state enum and round-robin pick function in package stream_arb_pkg.
REQ-027 SHALL implement priority/round-robin selection as sub-module stream_arb_rr_pick (combinational, inputs: valid, qos, last id; output: grant id, found).

Verification (STREAM_COUNT=4, QoS 4 bits)
REQ-028 SHALL cover: valid=0101, qos={_,3,_,7} on streams 0/2 -> stream 2 granted, m_id_o=2, m_qos_o=7.
REQ-029 SHALL cover: all valid, qos all 5, 1-beat packets, repeated -> grant order 0,1,2,3,0.
REQ-030 SHALL cover: stream1 qos 0, stream3 qos 9, both valid, last id 1 -> stream 3 then stream 1.
REQ-031 SHALL cover: 4-beat packet on stream 0 with m_ready_i toggling 1010 -> 4 output beats in order, last on 4th, stream 2 valid mid-packet not granted until after.
REQ-032 SHALL cover: rst_i pulsed during beat 2 of packet -> all outputs 0 next edge, stream 0 wins first tie after release.
REQ-033 SHALL cover: STREAM_ARB_BACK2BACK_EN defined, two 2-beat packets queued -> 4 consecutive m_valid_o beats, no gap.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared FSM type and round-robin search helper for the QoS stream arbiter.
package stream_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } arb_state_t;

   localparam int MAX_STREAMS = 16;

   // {found, index} of the first set bit of cand strictly after 'last', wrapping at n.
   function automatic logic [4:0] rr_first(
      input logic [MAX_STREAMS-1:0] cand,
      input logic [3:0]             last,
      input int                     n
   );
      logic [4:0] res;
      int         idx;
      res = '0;
      for (int k = MAX_STREAMS; k >= 1; k--) begin
         idx = int'(last) + k;
         if (idx >= n) idx = idx - n;
         if (k <= n && cand[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/stream_arb_rr_pick.sv
// Combinational winner selection: highest QoS among valid streams, QoS 0 ranks with the top
// level, ties broken round-robin after the last granted id.
module stream_arb_rr_pick
   import stream_arb_pkg::*;
#(
   parameter int STREAM_COUNT = 4,
   parameter int T_QOS__WIDTH = 4,
   parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
   input  logic [STREAM_COUNT-1:0] i_valid,
   input  logic [T_QOS__WIDTH-1:0] i_qos [STREAM_COUNT],
   input  logic [T_ID___WIDTH-1:0] i_last_id,
   output logic [T_ID___WIDTH-1:0] o_grant_id,
   output logic                    o_found
);

   logic [T_QOS__WIDTH-1:0] w_max_qos;
   logic [STREAM_COUNT-1:0] w_cand;
   logic [4:0]              w_pick;

   always_comb begin
      w_max_qos = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         if (i_valid[i] && (i_qos[i] > w_max_qos)) w_max_qos = i_qos[i];
      end
      w_cand = '0;
      for (int i = 0; i < STREAM_COUNT; i++) begin
         w_cand[i] = i_valid[i] && ((i_qos[i] == w_max_qos) || (i_qos[i] == '0));
      end
   end

   assign w_pick     = rr_first(MAX_STREAMS'(w_cand), 4'(i_last_id), STREAM_COUNT);
   assign o_found    = w_pick[4];
   assign o_grant_id = T_ID___WIDTH'(w_pick[3:0]);

endmodule

// File: rtl/stream_arbiter_qos_rr.sv
// Packet-locked QoS / round-robin stream arbiter with a one-beat registered output stage.
// Define STREAM_ARB_BACK2BACK_EN to re-arbitrate on the last beat and drop the idle bubble.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no grant; arbitrate among valid streams
//   ST_PKT  | stream r_grant locked until its last beat is accepted
module stream_arbiter_qos_rr
   import stream_arb_pkg::*;
#(
   parameter int T_DATA_WIDTH = 8,
   parameter int T_QOS__WIDTH = 4,
   parameter int STREAM_COUNT = 4,
   parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [T_DATA_WIDTH-1:0] s_data_i  [STREAM_COUNT],
   input  logic [T_QOS__WIDTH-1:0] s_qos_i   [STREAM_COUNT],
   input  logic [STREAM_COUNT-1:0] s_last_i,
   input  logic [STREAM_COUNT-1:0] s_valid_i,
   output logic [STREAM_COUNT-1:0] s_ready_o,
   output logic [T_DATA_WIDTH-1:0] m_data_o,
   output logic [T_QOS__WIDTH-1:0] m_qos_o,
   output logic [T_ID___WIDTH-1:0] m_id_o,
   output logic                    m_last_o,
   output logic                    m_valid_o,
   input  logic                    m_ready_i
);

   arb_state_t              r_state;
   arb_state_t              w_state_nxt;
   logic [T_ID___WIDTH-1:0] r_grant;       // doubles as the round-robin pointer
   logic [T_QOS__WIDTH-1:0] r_grant_qos;
   logic [STREAM_COUNT-1:0] w_pick_valid;
   logic [T_ID___WIDTH-1:0] w_pick_id;
   logic                    w_pick_found;
   logic                    w_out_free;
   logic                    w_accept;
   logic                    w_last_accept;
   logic                    w_load_grant;

   assign w_out_free = ~m_valid_o | m_ready_i;

`ifdef STREAM_ARB_BACK2BACK_EN
   // The locked stream's valid still belongs to its current packet, so it sits out the re-arbitration.
   always_comb begin
      w_pick_valid = s_valid_i;
      if (r_state == ST_PKT) w_pick_valid[r_grant] = 1'b0;
   end
`else
   assign w_pick_valid = s_valid_i;
`endif

   stream_arb_rr_pick #(
      .STREAM_COUNT (STREAM_COUNT),
      .T_QOS__WIDTH (T_QOS__WIDTH),
      .T_ID___WIDTH (T_ID___WIDTH)
   ) u_pick (
      .i_valid    (w_pick_valid),
      .i_qos      (s_qos_i),
      .i_last_id  (r_grant),
      .o_grant_id (w_pick_id),
      .o_found    (w_pick_found)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_load_grant = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) begin
               w_state_nxt  = ST_PKT;
               w_load_grant = 1'b1;
            end
         end
         ST_PKT: begin
            if (w_last_accept) begin
`ifdef STREAM_ARB_BACK2BACK_EN
               if (w_pick_found) w_load_grant = 1'b1;
               else              w_state_nxt  = ST_IDLE;
`else
               w_state_nxt = ST_IDLE;
`endif
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready_o = '0;
      if ((r_state == ST_PKT) && w_out_free) s_ready_o[r_grant] = 1'b1;
   end

   assign w_accept      = s_valid_i[r_grant] & s_ready_o[r_grant];
   assign w_last_accept = w_accept & s_last_i[r_grant];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_grant     <= T_ID___WIDTH'(STREAM_COUNT - 1);
         r_grant_qos <= '0;
      end else if (w_load_grant) begin
         r_grant     <= w_pick_id;
         r_grant_qos <= s_qos_i[w_pick_id];
      end
   end

   // id/qos travel with each beat so a pending last beat keeps its tags across a new grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
         m_data_o  <= '0;
         m_id_o    <= '0;
         m_qos_o   <= '0;
      end else if (w_accept) begin
         m_valid_o <= 1'b1;
         m_last_o  <= s_last_i[r_grant];
         m_data_o  <= s_data_i[r_grant];
         m_id_o    <= r_grant;
         m_qos_o   <= r_grant_qos;
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_arbiter_qos_rr.sv
// Self-checking bench for stream_arbiter_qos_rr: directed scenarios plus randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_stream_arbiter_qos_rr;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int QW = 4;
   localparam int IW = 2;
`ifdef STREAM_ARB_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
      logic [QW-1:0] q;
   } beat_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [DW-1:0] s_data_i [N];
   logic [QW-1:0] s_qos_i  [N];
   logic [N-1:0]  s_last_i;
   logic [N-1:0]  s_valid_i;
   logic [N-1:0]  s_ready_o;
   logic [DW-1:0] m_data_o;
   logic [QW-1:0] m_qos_o;
   logic [IW-1:0] m_id_o;
   logic          m_last_o;
   logic          m_valid_o;
   logic          m_ready_i;

   always #5 clk_i = ~clk_i;

   stream_arbiter_qos_rr #(
      .T_DATA_WIDTH (DW),
      .T_QOS__WIDTH (QW),
      .STREAM_COUNT (N)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .s_data_i  (s_data_i),
      .s_qos_i   (s_qos_i),
      .s_last_i  (s_last_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .m_data_o  (m_data_o),
      .m_qos_o   (m_qos_o),
      .m_id_o    (m_id_o),
      .m_last_o  (m_last_o),
      .m_valid_o (m_valid_o),
      .m_ready_i (m_ready_i)
   );

   // sources
   beat_t        srcq [N][$];
   logic [N-1:0] gap;
   logic [N-1:0] acc;
   bit           rand_mode;

   // reference model
   int            lock;
   int            last_ptr;
   logic [QW-1:0] lock_qos;
   bit            mv;
   bit            ml;
   logic [DW-1:0] md;
   int            mid;
   logic [QW-1:0] mqos;

   // observation logs for directed checks
   int            hs_id   [$];
   logic [DW-1:0] hs_data [$];
   bit            hs_last [$];
   bit            mv_trace[$];

   int n_err;
   int n_chk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Spec rule: top QoS among valid (qos 0 ranks as top), then first such index after last_ptr.
   function automatic int arb(input int excl);
      int maxq = -1;
      for (int i = 0; i < N; i++)
         if (s_valid_i[i] && i != excl && int'(s_qos_i[i]) > maxq) maxq = int'(s_qos_i[i]);
      if (maxq < 0) return -1;
      for (int k = 1; k <= N; k++) begin
         int i = (last_ptr + k) % N;
         if (s_valid_i[i] && i != excl && (int'(s_qos_i[i]) == maxq || s_qos_i[i] == 0)) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      lock = -1; last_ptr = N - 1; lock_qos = '0;
      mv = 0; ml = 0; md = '0; mid = 0; mqos = '0; acc = '0;
   endtask

   task automatic grant(input int w);
      lock = w; last_ptr = w; lock_qos = s_qos_i[w];
   endtask

   task automatic compare();
      logic [N-1:0] er;
      er = '0;
      if (lock >= 0 && (!mv || m_ready_i)) er[lock] = 1'b1;
      chk("s_ready", s_ready_o, er);
      chk("m_valid", m_valid_o, mv);
      if (mv || rst_i) begin
         chk("m_data", m_data_o, md);
         chk("m_last", m_last_o, ml);
         chk("m_id", m_id_o, mid);
         chk("m_qos", m_qos_o, mqos);
      end
   endtask

   task automatic model_next();
      int g;
      int w;
      bit take;
      acc = '0;
      if (rst_i) begin
         model_reset();
         return;
      end
      if (lock >= 0) begin
         g    = lock;
         take = s_valid_i[g] && (!mv || m_ready_i);
         if (take) begin
            acc[g] = 1'b1; mv = 1; md = s_data_i[g]; ml = s_last_i[g]; mid = g; mqos = lock_qos;
         end else if (m_ready_i) begin
            mv = 0;
         end
         if (take && s_last_i[g]) begin
            lock = -1;
            if (B2B) begin
               w = arb(g);
               if (w >= 0) grant(w);
            end
         end
      end else begin
         if (m_ready_i) mv = 0;
         w = arb(-1);
         if (w >= 0) grant(w);
      end
   endtask

   task automatic present();
      for (int i = 0; i < N; i++)
         if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      acc = '0;
      if (rand_mode) begin
         m_ready_i = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int            len;
               logic [QW-1:0] q;
               len = $urandom_range(1, 4);
               q   = QW'($urandom_range(0, 5));
               for (int b = 0; b < len; b++)
                  srcq[i].push_back('{d: DW'($urandom), last: (b == len - 1), q: q});
            end
            gap[i] = ($urandom_range(0, 7) == 0);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0) begin
            s_valid_i[i] = !gap[i];
            s_data_i[i]  = srcq[i][0].d;
            s_last_i[i]  = srcq[i][0].last;
            s_qos_i[i]   = srcq[i][0].q;
         end else begin
            s_valid_i[i] = 1'b0;
         end
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      compare();
      mv_trace.push_back(m_valid_o);
      if (m_valid_o && m_ready_i) begin
         hs_id.push_back(int'(m_id_o));
         hs_data.push_back(m_data_o);
         hs_last.push_back(m_last_o);
      end
      model_next();
      @(posedge clk_i);
      #1;
      present();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic push_pkt(input int s, input int len, input logic [QW-1:0] q, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++)
         srcq[s].push_back('{d: base + DW'(b), last: (b == len - 1), q: q});
   endtask

   task automatic do_reset();
      rst_i = 1'b1; rand_mode = 0; gap = '0; m_ready_i = 1'b1;
      for (int i = 0; i < N; i++) srcq[i].delete();
      model_reset();
      present();
      #1;
      chk("rst_outputs", {m_valid_o, m_last_o, m_data_o, m_qos_o, m_id_o, s_ready_o}, '0);
      step();
      step();
      rst_i = 1'b0;
      hs_id.delete(); hs_data.delete(); hs_last.delete(); mv_trace.delete();
   endtask

   initial begin
      int ord [5];
      int best;
      int runl;
      n_err = 0;
      n_chk = 0;
      s_last_i = '0;
      s_valid_i = '0;
      for (int i = 0; i < N; i++) begin
         s_data_i[i] = '0;
         s_qos_i[i]  = '0;
      end

      // higher QoS wins: stream 2 (qos 7) over stream 0 (qos 3)
      do_reset();
      push_pkt(0, 1, 4'd3, 8'h10);
      push_pkt(2, 1, 4'd7, 8'h20);
      present();
      step();
      step();
      chk("qos_win_valid", m_valid_o, 1);
      chk("qos_win_id", m_id_o, 2);
      chk("qos_win_qos", m_qos_o, 7);
      chk("qos_win_data", m_data_o, 8'h20);
      run(6);
      chk("qos_loser_next", (hs_id.size() >= 2) ? hs_id[1] : -1, 0);

      // equal QoS round-robin
      do_reset();
      push_pkt(0, 1, 4'd5, 8'h30);
      push_pkt(0, 1, 4'd5, 8'h34);
      push_pkt(1, 1, 4'd5, 8'h31);
      push_pkt(2, 1, 4'd5, 8'h32);
      push_pkt(3, 1, 4'd5, 8'h33);
      present();
      run(16);
      ord = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++)
         chk("rr_order", (hs_id.size() > k) ? hs_id[k] : -1, ord[k]);

      // qos 0 ties with the top level; round-robin from last id 1
      do_reset();
      push_pkt(1, 1, 4'd5, 8'h40);
      present();
      run(5);
      push_pkt(1, 1, 4'd0, 8'h50);
      push_pkt(3, 1, 4'd9, 8'h60);
      present();
      run(10);
      ord = '{1, 3, 1, 0, 0};
      for (int k = 0; k < 3; k++)
         chk("qos0_order", (hs_id.size() > k) ? hs_id[k] : -1, ord[k]);

      // 4-beat packet under toggling m_ready, competing stream arrives mid-packet
      do_reset();
      push_pkt(0, 4, 4'd2, 8'hA0);
      present();
      for (int k = 0; k < 20; k++) begin
         if (k == 3) begin
            push_pkt(2, 1, 4'd15, 8'hB0);
            present();
         end
         m_ready_i = (k % 2 == 0);
         step();
      end
      chk("pkt_count", hs_id.size(), 5);
      for (int k = 0; k < 4; k++) begin
         chk("pkt_data", (hs_data.size() > k) ? hs_data[k] : 8'hXX, 8'hA0 + 8'(k));
         chk("pkt_last", (hs_last.size() > k) ? hs_last[k] : 1'bx, (k == 3));
      end
      chk("pkt_after_id", (hs_id.size() > 4) ? hs_id[4] : -1, 2);

      // reset during beat 2, then stream 0 must win the first tie
      do_reset();
      push_pkt(0, 4, 4'd1, 8'hC0);
      present();
      step();
      step();
      do_reset();
      push_pkt(0, 1, 4'd4, 8'hD0);
      push_pkt(3, 1, 4'd4, 8'hD8);
      present();
      run(8);
      chk("rst_first_tie", (hs_id.size() > 0) ? hs_id[0] : -1, 0);
      chk("rst_first_data", (hs_data.size() > 0) ? hs_data[0] : 8'hXX, 8'hD0);

      // two queued 2-beat packets: bubble in default build, none with back-to-back
      do_reset();
      push_pkt(0, 2, 4'd6, 8'hE0);
      push_pkt(1, 2, 4'd6, 8'hE8);
      present();
      run(12);
      best = 0;
      runl = 0;
      foreach (mv_trace[i]) begin
         if (mv_trace[i]) begin
            runl++;
            if (runl > best) best = runl;
         end else begin
            runl = 0;
         end
      end
      chk("b2b_beats", hs_id.size(), 4);
      chk("b2b_run", best, B2B ? 4 : 2);

      // randomized traffic with a reset in the middle
      do_reset();
      rand_mode = 1;
      present();
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            do_reset();
            rand_mode = 1;
            present();
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
